// File: rtl/arm_trig_capture.sv
// Armed trigger capture controller.
// Waits in ARMED for a masked (level or rising-edge) trigger, waits a
// programmable delay, then drives a capture pulse of programmable width.
// delay/width are latched at the triggering edge so later changes on the
// inputs do not disturb an operation already in flight. abort returns to
// IDLE from anywhere. It takes priority over arm, trigger and counter expiry.
// Handshake: none. All inputs are sampled on every rising clk edge. All
// outputs are registered, so a change on an input shows up one edge later.
module arm_trig_capture #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm,
  input  logic           abort,
  input  logic [NCH-1:0] trigger,
  input  logic [NCH-1:0] trig_mask,
  input  logic           edge_mode,
  input  logic [CW-1:0]  delay,
  input  logic [CW-1:0]  width,
  input  logic           auto_rearm,
  output logic           capture,
  output logic           armed,
  output logic [NCH-1:0] trig_src,
  output logic [CW-1:0]  evt_count,
  output logic [1:0]     dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_DELAY   = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]     state, state_nx;
  logic [NCH-1:0] trig_prev;
  logic [NCH-1:0] qual;
  logic [NCH-1:0] hits;
  logic           hit;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [CW-1:0]  width_q, width_nx;
  logic [NCH-1:0] src_nx;
  logic           evt_inc;

  // The counter holds "cycles remaining minus one", so a width of 0 behaves as 1.
  function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] w);
    return (w == '0) ? '0 : (w - ONE);
  endfunction

  assign dbg_state = state;

  // Next-state, counter and latch decisions. abort overrides everything else.
  always_comb begin
    qual     = edge_mode ? ~trig_prev : '1;
    hits     = trigger & trig_mask & qual;
    hit      = |hits;
    state_nx = state;
    cnt_nx   = cnt;
    width_nx = width_q;
    src_nx   = trig_src;
    evt_inc  = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm) state_nx = S_ARMED;
        end
        S_ARMED: begin
          if (hit) begin
            src_nx   = hits;
            width_nx = width;
            if (delay != '0) begin
              state_nx = S_DELAY;
              cnt_nx   = delay - ONE;
            end else begin
              state_nx = S_CAPTURE;
              cnt_nx   = len_m1(width);
              evt_inc  = 1'b1;
            end
          end
        end
        S_DELAY: begin
          if (cnt == '0) begin
            state_nx = S_CAPTURE;
            cnt_nx   = len_m1(width_q);
            evt_inc  = 1'b1;
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
        default: begin
          if (cnt == '0) begin
            state_nx = auto_rearm ? S_ARMED : S_IDLE;
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
      endcase
    end
  end

  // State and output registers. capture and armed are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      width_q   <= '0;
      trig_prev <= '0;
      trig_src  <= '0;
      evt_count <= '0;
      capture   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      width_q   <= width_nx;
      trig_prev <= trigger;
      trig_src  <= src_nx;
      if (evt_inc) evt_count <= evt_count + ONE;
      capture   <= (state_nx == S_CAPTURE);
      armed     <= (state_nx == S_ARMED);
    end
  end

endmodule

// File: tb/tb_arm_trig_capture.sv
// Bench for arm_trig_capture. The reference model keeps capture windows
// as absolute cycle timestamps rather than stepping a state machine.
module tb_arm_trig_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0, abort = 1'b0, edge_mode = 1'b0, auto_rearm = 1'b0;
  logic [3:0] trigger = '0, trig_mask = '0, trig_src;
  logic [7:0] delay = '0, width = '0, evt_count;
  logic       capture, armed;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  string ctx = "reset";

  // clock
  always #5 clk = ~clk;

  arm_trig_capture #(.NCH(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trigger(trigger),
    .trig_mask(trig_mask), .edge_mode(edge_mode), .delay(delay), .width(width),
    .auto_rearm(auto_rearm), .capture(capture), .armed(armed),
    .trig_src(trig_src), .evt_count(evt_count), .dbg_state(dbg_state)
  );

  // reference model: mode 0 idle, 1 waiting for trigger, 2 busy with window [m_s, m_e)
  int         m_t, m_mode, m_s, m_e;
  logic [3:0] m_src, m_prev;
  logic [7:0] m_evt;
  bit         cap_seen;

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_s = 0; m_e = 0;
    m_src = '0; m_prev = '0; m_evt = '0;
  endtask

  task automatic model_edge();
    logic [3:0] h;
    m_t++;
    h = trigger & trig_mask & (edge_mode ? ~m_prev : 4'hf);
    if (abort) m_mode = 0;
    else if (m_mode == 0) begin
      if (arm) m_mode = 1;
    end else if (m_mode == 1) begin
      if (h != 0) begin
        m_src  = h;
        m_s    = m_t + int'(delay);
        m_e    = m_s + ((width == 0) ? 1 : int'(width));
        m_mode = 2;
      end
    end else if (m_t == m_e) m_mode = auto_rearm ? 1 : 0;
    if (m_mode == 2 && m_t == m_s) m_evt++;
    m_prev = trigger;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h at t=%0t", ctx, name, act, exp, $time);
    end
  endtask

  // one clock: model advances on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cap_seen = cap_seen | capture;
    chk("capture", 32'(capture), 32'(m_mode == 2 && m_t >= m_s));
    chk("armed", 32'(armed), 32'(m_mode == 1));
    chk("trig_src", 32'(trig_src), 32'(m_src));
    chk("evt_count", 32'(evt_count), 32'(m_evt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; arm = 0; abort = 0; trigger = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       arm, abort, ar;
    logic [3:0] trig;
    logic       e_cap, e_armed;
    logic [3:0] e_src;
    logic [7:0] e_evt;
  } vec_t;

  vec_t vt[10];
  logic [7:0] evt0;

  initial begin
    model_reset();
    #1;
    chk("rst_capture", 32'(capture), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_src", 32'(trig_src), 32'd0);
    chk("rst_evt", 32'(evt_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table: single-cycle trigger, masked channels, idle-ignore, abort priority
    trig_mask = 4'b0010; edge_mode = 0; delay = 0; width = 1;
    vt[0] = '{1,0,0,4'b0000, 0,1,4'b0000,8'd0};
    vt[1] = '{0,0,0,4'b0010, 1,0,4'b0010,8'd1};
    vt[2] = '{0,0,0,4'b0000, 0,0,4'b0010,8'd1};
    vt[3] = '{0,0,0,4'b0010, 0,0,4'b0010,8'd1};
    vt[4] = '{1,0,0,4'b0010, 0,1,4'b0010,8'd1};
    vt[5] = '{0,0,1,4'b0001, 0,1,4'b0010,8'd1};
    vt[6] = '{0,0,1,4'b0011, 1,0,4'b0010,8'd2};
    vt[7] = '{0,0,1,4'b0000, 0,1,4'b0010,8'd2};
    vt[8] = '{1,1,0,4'b0000, 0,0,4'b0010,8'd2};
    vt[9] = '{1,1,0,4'b0000, 0,0,4'b0010,8'd2};
    ctx = "table";
    for (int i = 0; i < 10; i++) begin
      arm = vt[i].arm; abort = vt[i].abort; auto_rearm = vt[i].ar; trigger = vt[i].trig;
      tick();
      chk($sformatf("v%0d_cap", i), 32'(capture), 32'(vt[i].e_cap));
      chk($sformatf("v%0d_armed", i), 32'(armed), 32'(vt[i].e_armed));
      chk($sformatf("v%0d_src", i), 32'(trig_src), 32'(vt[i].e_src));
      chk($sformatf("v%0d_evt", i), 32'(evt_count), 32'(vt[i].e_evt));
    end
    arm = 0; abort = 0;

    // delay 3, width 4, operands changed after the trigger edge
    ctx = "delay3w4";
    do_reset();
    trig_mask = 4'hf; delay = 3; width = 4; auto_rearm = 0;
    arm = 1; tick(); arm = 0;
    trigger = 4'b0100; tick(); trigger = 0;
    delay = 0; width = 9;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("no_cap_yet", 32'(capture), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cap_window", 32'(capture), 32'd1);
      chk("armed_low", 32'(armed), 32'd0);
    end
    tick();
    chk("cap_end", 32'(capture), 32'd0);
    chk("evt_once", 32'(evt_count), 32'd1);

    // edge mode with a held level: exactly one capture per rising edge
    ctx = "edge_hold";
    do_reset();
    trig_mask = 4'b0001; edge_mode = 1; auto_rearm = 1; delay = 0; width = 2;
    arm = 1; tick(); arm = 0;
    trigger = 4'b0001;
    for (int i = 0; i < 20; i++) tick();
    chk("one_capture", 32'(evt_count), 32'd1);
    chk("rearmed", 32'(armed), 32'd1);
    trigger = 0; tick(); trigger = 4'b0001; tick(); tick(); tick();
    chk("second_capture", 32'(evt_count), 32'd2);

    // abort in the second DELAY cycle, then abort mid-capture
    ctx = "abort";
    do_reset();
    edge_mode = 0; trig_mask = 4'hf; delay = 5; width = 3; auto_rearm = 0;
    arm = 1; tick(); arm = 0;
    trigger = 4'b1000; tick(); trigger = 0;
    tick();
    cap_seen = 0;
    abort = 1; tick(); abort = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("never_cap", 32'(cap_seen), 32'd0);
    chk("evt_kept", 32'(evt_count), 32'd0);
    delay = 0; width = 6;
    arm = 1; tick(); arm = 0;
    trigger = 4'b0001; tick(); trigger = 0; tick();
    chk("in_capture", 32'(capture), 32'd1);
    abort = 1; tick(); abort = 0;
    chk("cap_dropped", 32'(capture), 32'd0);

    // mask zero: toggling triggers never fire
    ctx = "mask0";
    trig_mask = 0;
    arm = 1; tick(); arm = 0;
    evt0 = evt_count;
    cap_seen = 0;
    for (int i = 0; i < 50; i++) begin
      trigger = 4'(~trigger);
      tick();
    end
    chk("mask_no_cap", 32'(cap_seen), 32'd0);
    chk("mask_armed", 32'(armed), 32'd1);
    chk("mask_evt", 32'(evt_count), 32'(evt0));

    // 256 captures wrap the counter
    ctx = "wrap";
    do_reset();
    trig_mask = 4'hf; edge_mode = 0; delay = 0; width = 1; auto_rearm = 1;
    arm = 1; tick(); arm = 0;
    trigger = 4'b0001;
    for (int i = 0; i < 512; i++) tick();
    trigger = 0; abort = 1; tick(); abort = 0;
    chk("wrapped", 32'(evt_count), 32'd0);

    // async reset between edges during capture
    ctx = "async_rst";
    do_reset();
    delay = 0; width = 10; auto_rearm = 0;
    arm = 1; tick(); arm = 0;
    trigger = 4'b0010; tick(); trigger = 0; tick();
    chk("pre_rst_cap", 32'(capture), 32'd1);
    #2 rst = 1;
    #1;
    chk("ar_capture", 32'(capture), 32'd0);
    chk("ar_armed", 32'(armed), 32'd0);
    chk("ar_src", 32'(trig_src), 32'd0);
    chk("ar_evt", 32'(evt_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    arm = 1; tick(); arm = 0;
    chk("ar_rearm", 32'(armed), 32'd1);

    // random traffic against the model
    ctx = "random";
    for (int i = 0; i < 3000; i++) begin
      arm = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 29) == 0);
      trigger = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) trig_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) edge_mode = 1'($urandom_range(0, 1));
      delay = 8'($urandom_range(0, 4));
      width = 8'($urandom_range(0, 3));
      auto_rearm = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_trig_capture.md
ARM_TRIG_CAPTURE -- requirements
Module: arm_trig_capture

Interface
REQ-001 SHALL have parameter NCH, default 4, number of trigger channels (1..32).
REQ-002 SHALL have parameter CW, default 8, width of delay/width operands and event counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port arm  input  1  request to leave IDLE and wait for a trigger.
REQ-006 SHALL have port abort  input  1  unconditional return to IDLE.
REQ-007 SHALL have port trigger  input  NCH  per-channel trigger inputs.
REQ-008 SHALL have port trig_mask  input  NCH  per-channel enable; 1 = channel may trigger.
REQ-009 SHALL have port edge_mode  input  1  0 = level-sensitive, 1 = rising-edge-sensitive triggers.
REQ-010 SHALL have port delay  input  CW  cycles from trigger to capture start.
REQ-011 SHALL have port width  input  CW  capture pulse length in cycles; 0 treated as 1.
REQ-012 SHALL have port auto_rearm  input  1  1 = return to ARMED after capture, 0 = return to IDLE.
REQ-013 SHALL have port capture  output  1  registered capture pulse.
REQ-014 SHALL have port armed  output  1  high while in ARMED.
REQ-015 SHALL have port trig_src  output  NCH  channels that caused the most recent trigger.
REQ-016 SHALL have port evt_count  output  CW  number of captures started, modulo 2^CW.

Function
REQ-017 SHALL implement states IDLE, ARMED, DELAY, CAPTURE; capture = (state==CAPTURE), armed = (state==ARMED), both registered.
REQ-018 SHALL define hit = |(trigger & trig_mask & qual), qual = all ones when edge_mode=0, ~trigger_prev when edge_mode=1.
REQ-019 SHALL update trigger_prev from trigger every cycle in every state.
REQ-020 IDLE: arm=1 -> ARMED next cycle; trigger ignored in IDLE, including the cycle arm is sampled.
REQ-021 ARMED: hit=1 -> latch trig_src = trigger & trig_mask & qual, latch delay and width; go DELAY if delay!=0, else CAPTURE.
REQ-022 ARMED: arm ignored; hit=0 -> remain ARMED indefinitely.
REQ-023 DELAY: remain exactly delay cycles, then CAPTURE; trigger and arm ignored.
REQ-024 Latency: hit sampled at edge k -> capture first high after edge k+delay, low after edge k+delay+max(width,1).
REQ-025 CAPTURE: remain max(latched width,1) cycles; then ARMED if auto_rearm=1 (sampled in last capture cycle), else IDLE.
REQ-026 Changes to delay/width after the triggering edge SHALL NOT affect the operation in progress.
REQ-027 evt_count SHALL increment by 1 on each entry to CAPTURE, wrapping 2^CW-1 -> 0.
REQ-028 abort=1 SHALL force IDLE at the next edge from any state, with priority over arm, hit and counter expiry; capture low the following cycle.
REQ-029 abort with arm in IDLE -> remain IDLE.
REQ-030 trig_mask all zero -> no trigger ever; trig_src and evt_count unchanged.
REQ-031 Auto-rearmed ARMED with edge_mode=1 SHALL require a fresh rising edge; a still-high level SHALL NOT retrigger.

Reset
REQ-032 rst=1 SHALL immediately, without clock, force state IDLE, capture=0, armed=0, trig_src=0, evt_count=0, trigger_prev=0, internal counters 0.
REQ-033 Deassertion of rst SHALL be taken synchronously; first state change no earlier than the first edge after deassertion.

Verification
REQ-034 NCH=4, mask=4'b0010, edge_mode=0, delay=0, width=1: arm pulse, then trigger=4'b0010 one cycle -> capture high exactly 1 cycle after trigger edge, trig_src=4'b0010, evt_count=1, state IDLE.
REQ-035 delay=3, width=4, auto_rearm=0: trigger at edge k -> capture high edges k+3..k+7 window (4 cycles), armed low throughout, evt_count increments once.
REQ-036 edge_mode=1, auto_rearm=1, trigger[0] held high 20 cycles, mask=4'b0001 -> exactly one capture; armed returns high; second rising edge -> second capture, evt_count=2.
REQ-037 abort asserted in second cycle of DELAY (delay=5) -> IDLE next edge, capture never asserts, evt_count unchanged; abort mid-CAPTURE -> capture drops next cycle.
REQ-038 mask=0 with all triggers toggling 50 cycles while ARMED -> no capture, armed stays high; 256 captures with CW=8 -> evt_count wraps to 0.
REQ-039 rst pulsed asynchronously between edges during CAPTURE -> capture, armed, trig_src, evt_count go 0 immediately; arm after release -> normal ARMED.
